// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-requester ALU arbiter: opcode encoding and FSM states.
package alu_arbiter_pkg;

   typedef enum logic [1:0] {
      ADD = 2'b00,
      SUB = 2'b01,
      AND = 2'b10,
      OR  = 2'b11
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by both requesters; ADD/SUB wrap, carry/borrow dropped.
module basic_alu
   import alu_arbiter_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = '0;
      case (alu_op_t'(op))
         ADD:     y = a + b;
         SUB:     y = a - b;
         AND:     y = a & b;
         OR:      y = a | b;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter feeding one shared ALU: accept in IDLE, compute in EXEC,
// hold the registered result in RESP until the consumer takes it.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [1:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [1:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             req1_ready,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_y,
   input  logic             rsp_ready,
   output logic             busy
);

   state_t           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   alu_op_t          op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             id_q, id_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
   logic [WIDTH-1:0] alu_y;
   logic             grant0, grant1;

   basic_alu #(.WIDTH(WIDTH)) u_alu (
      .op (op_q),
      .a  (a_q),
      .b  (b_q),
      .y  (alu_y)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      id_d         = id_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_y_d      = rsp_y_q;

      // On contention the requester that did not win last time gets the slot.
      grant0     = req0_valid & (~req1_valid | last_grant_q);
      grant1     = req1_valid & (~req0_valid | ~last_grant_q);
      req0_ready = (state_q == IDLE) & ~rst & grant0;
      req1_ready = (state_q == IDLE) & ~rst & grant1;

      case (state_q)
         IDLE: begin
            if (req1_ready) begin
               op_d         = alu_op_t'(req1_op);
               a_d          = req1_a;
               b_d          = req1_b;
               id_d         = 1'b1;
               last_grant_d = 1'b1;
               state_d      = EXEC;
            end else if (req0_ready) begin
               op_d         = alu_op_t'(req0_op);
               a_d          = req0_a;
               b_d          = req0_b;
               id_d         = 1'b0;
               last_grant_d = 1'b0;
               state_d      = EXEC;
            end
         end
         EXEC: begin
            rsp_y_d     = alu_y;
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         op_q         <= ADD;
         a_q          <= '0;
         b_q          <= '0;
         id_q         <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_y_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         id_q         <= id_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_y_q      <= rsp_y_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_y     = rsp_y_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: inputs driven and outputs checked on the falling edge.
module tb_alu_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req1_valid;
   logic [1:0] req0_op, req1_op;
   logic [3:0] req0_a, req0_b, req1_a, req1_b;
   logic       req0_ready, req1_ready;
   logic       rsp_valid, rsp_id, rsp_ready, busy;
   logic [3:0] rsp_y;

   int tests = 0;
   int fails = 0;

   alu_arbiter #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .req1_ready(req1_ready),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_ready(rsp_ready),
      .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] ref_alu(input logic [1:0] op, input logic [3:0] a,
                                          input logic [3:0] b);
      logic [4:0] t;
      case (op)
         2'b00: begin t = {1'b0, a} + {1'b0, b}; ref_alu = t[3:0]; end
         2'b01: begin t = {1'b1, a} - {1'b0, b}; ref_alu = t[3:0]; end
         2'b10: ref_alu = a & b;
         default: ref_alu = a | b;
      endcase
   endfunction

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
      req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
   endtask

   task automatic test_reset();
      rst = 1; rsp_ready = 1;
      req0_valid = 1; req1_valid = 1;
      step();
      tests++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
         fails++; $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready);
      end
      step();
      tests++;
      if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_y !== 4'h0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs: got v=%b id=%b y=%h busy=%b expected 0 0 0 0",
                  rsp_valid, rsp_id, rsp_y, busy);
      end
      idle_inputs();
      rst = 0;
      step();
   endtask

   task automatic test_single();
      rsp_ready = 1;
      req0_valid = 1; req0_op = 2'b00; req0_a = 4'h7; req0_b = 4'h3;
      #1;
      tests++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         fails++; $display("FAIL single_grant: got %b%b expected 10", req0_ready, req1_ready);
      end
      step();
      req0_valid = 0;
      #1;
      tests++;
      if (busy !== 1'b1 || rsp_valid !== 1'b0 || req0_ready !== 1'b0) begin
         fails++;
         $display("FAIL single_exec: got busy=%b v=%b rdy=%b expected 1 0 0", busy, rsp_valid, req0_ready);
      end
      step();
      tests++;
      if (rsp_valid !== 1'b1 || rsp_y !== 4'hA || rsp_id !== 1'b0 || busy !== 1'b1) begin
         fails++;
         $display("FAIL single_resp: got v=%b y=%h id=%b busy=%b expected 1 a 0 1",
                  rsp_valid, rsp_y, rsp_id, busy);
      end
      step();
      tests++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
         fails++; $display("FAIL single_idle: got busy=%b v=%b expected 0 0", busy, rsp_valid);
      end
   endtask

   task automatic test_wrap();
      logic [1:0] ops [2] = '{2'b00, 2'b01};
      logic [3:0] as  [2] = '{4'hF, 4'h2};
      logic [3:0] bs  [2] = '{4'h2, 4'h5};
      logic [3:0] exp [2] = '{4'h1, 4'hD};
      rsp_ready = 1;
      for (int i = 0; i < 2; i++) begin
         req1_valid = 1; req1_op = ops[i]; req1_a = as[i]; req1_b = bs[i];
         #1;
         tests++;
         if (req1_ready !== 1'b1) begin
            fails++; $display("FAIL wrap_grant[%0d]: got %b expected 1", i, req1_ready);
         end
         step();
         req1_valid = 0;
         step();
         tests++;
         if (rsp_valid !== 1'b1 || rsp_y !== exp[i] || rsp_id !== 1'b1) begin
            fails++;
            $display("FAIL wrap_resp[%0d]: got v=%b y=%h id=%b expected 1 %h 1",
                     i, rsp_valid, rsp_y, rsp_id, exp[i]);
         end
         step();
      end
   endtask

   task automatic test_contention();
      rst = 1; step(); rst = 0;
      rsp_ready = 1;
      req0_valid = 1; req0_op = 2'b10; req0_a = 4'hC; req0_b = 4'hA;
      req1_valid = 1; req1_op = 2'b11; req1_a = 4'hC; req1_b = 4'hA;
      #1;
      for (int k = 0; k < 4; k++) begin
         logic       exp_id;
         logic [3:0] exp_y;
         exp_id = k[0];
         exp_y  = exp_id ? 4'hE : 4'h8;
         tests++;
         if (req0_ready !== ~exp_id || req1_ready !== exp_id) begin
            fails++;
            $display("FAIL contention_grant[%0d]: got %b%b expected %b%b",
                     k, req0_ready, req1_ready, ~exp_id, exp_id);
         end
         step();
         step();
         tests++;
         if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_y !== exp_y) begin
            fails++;
            $display("FAIL contention_resp[%0d]: got v=%b id=%b y=%h expected 1 %b %h",
                     k, rsp_valid, rsp_id, rsp_y, exp_id, exp_y);
         end
         step();
      end
      idle_inputs();
      step();
   endtask

   task automatic test_backpressure();
      rsp_ready = 0;
      req0_valid = 1; req0_op = 2'b00; req0_a = 4'h1; req0_b = 4'h1;
      step();
      // Inputs scrambled while in flight must not disturb the result.
      req0_op = 2'b11; req0_a = 4'hF; req0_b = 4'hF;
      req1_valid = 1; req1_op = 2'b01; req1_a = 4'h9; req1_b = 4'h4;
      step();
      for (int c = 0; c < 5; c++) begin
         tests++;
         if (rsp_valid !== 1'b1 || rsp_y !== 4'h2 || rsp_id !== 1'b0 ||
             req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            fails++;
            $display("FAIL backpressure_hold[%0d]: got v=%b y=%h id=%b rdy=%b%b expected 1 2 0 00",
                     c, rsp_valid, rsp_y, rsp_id, req0_ready, req1_ready);
         end
         if (c < 4) step();
      end
      rsp_ready = 1;
      step();
      tests++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
         fails++;
         $display("FAIL backpressure_release: got busy=%b v=%b rdy=%b%b expected 0 0 01",
                  busy, rsp_valid, req0_ready, req1_ready);
      end
      step();
      idle_inputs();
      step();
      tests++;
      if (rsp_valid !== 1'b1 || rsp_y !== 4'h5 || rsp_id !== 1'b1) begin
         fails++;
         $display("FAIL backpressure_next: got v=%b y=%h id=%b expected 1 5 1", rsp_valid, rsp_y, rsp_id);
      end
      step();
   endtask

   task automatic test_reset_mid();
      rsp_ready = 1;
      req0_valid = 1; req0_op = 2'b00; req0_a = 4'h3; req0_b = 4'h3;
      step();
      idle_inputs();
      rst = 1;
      step();
      rst = 0;
      #1;
      tests++;
      if (rsp_valid !== 1'b0 || rsp_y !== 4'h0 || rsp_id !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_outputs: got v=%b y=%h id=%b busy=%b expected 0 0 0 0",
                  rsp_valid, rsp_y, rsp_id, busy);
      end
      for (int c = 0; c < 3; c++) begin
         step();
         tests++;
         if (rsp_valid !== 1'b0) begin
            fails++; $display("FAIL reset_mid_novalid[%0d]: got %b expected 0", c, rsp_valid);
         end
      end
      req0_valid = 1; req1_valid = 1;
      #1;
      tests++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         fails++; $display("FAIL reset_mid_grant: got %b%b expected 10", req0_ready, req1_ready);
      end
      step();
      idle_inputs();
      step(); step();
   endtask

   task automatic test_exhaustive();
      int bad = 0;
      rsp_ready = 1;
      for (int op = 0; op < 4; op++)
         for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) begin
               logic [3:0] exp_y;
               exp_y = ref_alu(op[1:0], a[3:0], b[3:0]);
               req0_valid = 1; req0_op = op[1:0]; req0_a = a[3:0]; req0_b = b[3:0];
               step();
               req0_valid = 0;
               step();
               tests++;
               if (rsp_valid !== 1'b1 || rsp_y !== exp_y || rsp_id !== 1'b0) begin
                  fails++;
                  if (bad < 10)
                     $display("FAIL exhaustive op=%0d a=%h b=%h: got v=%b y=%h id=%b expected 1 %h 0",
                              op, a[3:0], b[3:0], rsp_valid, rsp_y, rsp_id, exp_y);
                  bad++;
               end
               step();
            end
   endtask

   initial begin
      idle_inputs();
      rst = 1; rsp_ready = 1;
      test_reset();
      test_single();
      test_wrap();
      test_contention();
      test_backpressure();
      test_reset_mid();
      test_exhaustive();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
